dsp_rdata_channel: RTL and testbench

Read-data return path of the AXI4 interconnect dispatcher: the master-side counterpart of the read-address dispatcher. It records, in AR-acceptance order, which slave each outstanding read targets and its burst length. It then steers R beats from the corresponding slave-arbitration port back to the master, strictly in that order. It generates the master RLAST from its own beat count and flags slaves whose RLAST disagrees.

---
 rtl/dsp_rdata_channel.sv | 118 +++++++++++
 tb/tb_dsp_rdata_channel.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_rdata_channel.sv
// AXI4 read-data return path: steers R beats from slave-arbitration ports to the
// master in AR-acceptance order, generating RLAST from a local beat count.
module dsp_rdata_channel #(
    parameter int SLV_AMT          = 2,
    parameter int OUTSTANDING_AMT  = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int TRANS_MST_ID_W   = 5,
    parameter int TRANS_DATA_LEN_W = 3,
    parameter int TRANS_RESP_W     = 2,
    parameter int SLV_ID_W         = $clog2(SLV_AMT)
) (
    input  logic                               ACLK_i,
    input  logic                               ARESET_i,
    input  logic                               ord_push_i,
    input  logic [SLV_ID_W-1:0]                ord_slv_id_i,
    input  logic [TRANS_DATA_LEN_W-1:0]        ord_len_i,
    output logic                               ord_full_o,
    output logic                               ord_empty_o,
    input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]  sa_RID_i,
    input  logic [DATA_WIDTH*SLV_AMT-1:0]      sa_RDATA_i,
    input  logic [TRANS_RESP_W*SLV_AMT-1:0]    sa_RRESP_i,
    input  logic [SLV_AMT-1:0]                 sa_RLAST_i,
    input  logic [SLV_AMT-1:0]                 sa_RVALID_i,
    output logic [SLV_AMT-1:0]                 sa_RREADY_o,
    output logic [TRANS_MST_ID_W-1:0]          m_RID_o,
    output logic [DATA_WIDTH-1:0]              m_RDATA_o,
    output logic [TRANS_RESP_W-1:0]            m_RRESP_o,
    output logic                               m_RLAST_o,
    output logic                               m_RVALID_o,
    input  logic                               m_RREADY_i,
    output logic                               last_err_o
);

    localparam int PTR_W = $clog2(OUTSTANDING_AMT);

    logic [PTR_W:0]                wr_ptr;
    logic [PTR_W:0]                rd_ptr;
    logic [SLV_ID_W-1:0]           ord_slv_mem [OUTSTANDING_AMT];
    logic [TRANS_DATA_LEN_W-1:0]   ord_len_mem [OUTSTANDING_AMT];

    logic [SLV_ID_W-1:0]           head_slv;
    logic [TRANS_DATA_LEN_W-1:0]   head_len;
    logic [TRANS_DATA_LEN_W-1:0]   beat_cnt;

    logic fifo_full;
    logic fifo_empty;
    logic push_ok;
    logic handshake;
    logic local_last;
    logic pop;
    logic head_rlast;
    logic last_err_q;

    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push_ok    = ord_push_i & ~fifo_full;

    assign head_slv   = ord_slv_mem[rd_ptr[PTR_W-1:0]];
    assign head_len   = ord_len_mem[rd_ptr[PTR_W-1:0]];

    assign ord_full_o  = fifo_full;
    assign ord_empty_o = fifo_empty;

    always_comb begin
        m_RID_o     = '0;
        m_RDATA_o   = '0;
        m_RRESP_o   = '0;
        m_RVALID_o  = 1'b0;
        sa_RREADY_o = '0;
        head_rlast  = 1'b0;
        if (!fifo_empty) begin
            for (int unsigned k = 0; k < SLV_AMT; k++) begin
                if (SLV_ID_W'(k) == head_slv) begin
                    m_RID_o        = sa_RID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                    m_RDATA_o      = sa_RDATA_i[k*DATA_WIDTH +: DATA_WIDTH];
                    m_RRESP_o      = sa_RRESP_i[k*TRANS_RESP_W +: TRANS_RESP_W];
                    m_RVALID_o     = sa_RVALID_i[k];
                    head_rlast     = sa_RLAST_i[k];
                    sa_RREADY_o[k] = m_RREADY_i;
                end
            end
        end
    end

    assign handshake  = m_RVALID_o & m_RREADY_i;
    assign local_last = (beat_cnt == head_len);
    assign pop        = handshake & local_last;
    assign m_RLAST_o  = m_RVALID_o & local_last;
    assign last_err_o = last_err_q;

    always_ff @(posedge ACLK_i) begin
        if (push_ok) begin
            ord_slv_mem[wr_ptr[PTR_W-1:0]] <= ord_slv_id_i;
            ord_len_mem[wr_ptr[PTR_W-1:0]] <= ord_len_i;
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
            last_err_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (handshake)
                beat_cnt <= pop ? '0 : beat_cnt + TRANS_DATA_LEN_W'(1);
            // Slave RLAST is only audited; the local count alone drives the pop.
            last_err_q <= handshake & (head_rlast != local_last);
        end
    end

endmodule

// File: tb/tb_dsp_rdata_channel.sv
// Directed bench for dsp_rdata_channel: ordering, RLAST generation, full/drop,
// backpressure, RLAST mismatch flagging and mid-burst reset.
module tb_dsp_rdata_channel;

    logic        clk = 1'b0;
    logic        rst;
    logic        ord_push;
    logic [0:0]  ord_slv_id;
    logic [2:0]  ord_len;
    logic        ord_full;
    logic        ord_empty;
    logic [9:0]  sa_rid;
    logic [63:0] sa_rdata;
    logic [3:0]  sa_rresp;
    logic [1:0]  sa_rlast;
    logic [1:0]  sa_rvalid;
    logic [1:0]  sa_rready;
    logic [4:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic        last_err;

    int vectors = 0;
    int errors  = 0;

    dsp_rdata_channel #(
        .SLV_AMT(2), .OUTSTANDING_AMT(8), .DATA_WIDTH(32),
        .TRANS_MST_ID_W(5), .TRANS_DATA_LEN_W(3), .TRANS_RESP_W(2)
    ) dut (
        .ACLK_i(clk), .ARESET_i(rst),
        .ord_push_i(ord_push), .ord_slv_id_i(ord_slv_id), .ord_len_i(ord_len),
        .ord_full_o(ord_full), .ord_empty_o(ord_empty),
        .sa_RID_i(sa_rid), .sa_RDATA_i(sa_rdata), .sa_RRESP_i(sa_rresp),
        .sa_RLAST_i(sa_rlast), .sa_RVALID_i(sa_rvalid), .sa_RREADY_o(sa_rready),
        .m_RID_o(m_rid), .m_RDATA_o(m_rdata), .m_RRESP_o(m_rresp),
        .m_RLAST_o(m_rlast), .m_RVALID_o(m_rvalid), .m_RREADY_i(m_rready),
        .last_err_o(last_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slv(input int k, input logic [4:0] id, input logic [31:0] data,
                             input logic [1:0] resp, input logic last, input logic valid);
        sa_rid[k*5 +: 5]     = id;
        sa_rdata[k*32 +: 32] = data;
        sa_rresp[k*2 +: 2]   = resp;
        sa_rlast[k]          = last;
        sa_rvalid[k]         = valid;
    endtask

    task automatic idle_inputs();
        ord_push   = 1'b0;
        ord_slv_id = '0;
        ord_len    = '0;
        sa_rid     = '0;
        sa_rdata   = '0;
        sa_rresp   = '0;
        sa_rlast   = '0;
        sa_rvalid  = '0;
        m_rready   = 1'b0;
    endtask

    task automatic push(input logic [0:0] slv, input logic [2:0] len);
        ord_push = 1'b1; ord_slv_id = slv; ord_len = len;
        tick();
        ord_push = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        vectors++; if (ord_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", ord_empty); end
        vectors++; if (ord_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", ord_full); end
        vectors++; if (m_rvalid !== 1'b0 || m_rlast !== 1'b0) begin errors++; $display("FAIL reset_rvalid_rlast got %b%b want 00", m_rvalid, m_rlast); end
        vectors++; if (sa_rready !== 2'b00) begin errors++; $display("FAIL reset_sa_rready got %b want 00", sa_rready); end
        vectors++; if (last_err !== 1'b0) begin errors++; $display("FAIL reset_last_err got %b want 0", last_err); end
        vectors++; if (m_rdata !== 32'h0 || m_rid !== 5'h0 || m_rresp !== 2'h0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", m_rdata, m_rid, m_rresp); end
    endtask

    task automatic test_single();
        // Beat offered while the FIFO is still empty must not be accepted.
        drive_slv(1, 5'h13, 32'hA0, 2'b01, 1'b0, 1'b1);
        m_rready = 1'b1;
        ord_push = 1'b1; ord_slv_id = 1'b1; ord_len = 3'd3;
        #1;
        vectors++; if (m_rvalid !== 1'b0 || sa_rready !== 2'b00) begin errors++; $display("FAIL single_empty_block got v=%b rdy=%b want 0/00", m_rvalid, sa_rready); end
        tick();
        ord_push = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive_slv(1, 5'h13, 32'hA0 + b, 2'b01, (b == 3), 1'b1);
            #1;
            vectors++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hA0 + b || m_rid !== 5'h13 || m_rresp !== 2'b01) begin errors++; $display("FAIL single_beat%0d got v=%b d=%h id=%h r=%b want 1/%h/13/01", b, m_rvalid, m_rdata, m_rid, m_rresp, 32'hA0 + b); end
            vectors++; if (m_rlast !== (b == 3)) begin errors++; $display("FAIL single_rlast%0d got %b want %b", b, m_rlast, (b == 3)); end
            vectors++; if (sa_rready !== 2'b10) begin errors++; $display("FAIL single_rready%0d got %b want 10", b, sa_rready); end
            tick();
            vectors++; if (last_err !== 1'b0) begin errors++; $display("FAIL single_err%0d got %b want 0", b, last_err); end
        end
        vectors++; if (ord_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after got %b want 1", ord_empty); end
        idle_inputs();
    endtask

    task automatic test_ordering();
        push(1'b0, 3'd1);
        push(1'b1, 3'd0);
        drive_slv(1, 5'h02, 32'hB1, 2'b00, 1'b1, 1'b1);
        m_rready = 1'b1;
        #1;
        vectors++; if (m_rvalid !== 1'b0 || sa_rready !== 2'b01) begin errors++; $display("FAIL order_hold got v=%b rdy=%b want 0/01", m_rvalid, sa_rready); end
        tick();
        for (int b = 0; b < 2; b++) begin
            drive_slv(0, 5'h01, 32'hC0 + b, 2'b00, (b == 1), 1'b1);
            #1;
            vectors++; if (m_rdata !== 32'hC0 + b || m_rvalid !== 1'b1 || m_rlast !== (b == 1) || sa_rready !== 2'b01) begin errors++; $display("FAIL order_slv0_beat%0d got d=%h v=%b l=%b rdy=%b want %h/1/%b/01", b, m_rdata, m_rvalid, m_rlast, sa_rready, 32'hC0 + b, (b == 1)); end
            tick();
        end
        drive_slv(0, 5'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        #1;
        vectors++; if (m_rdata !== 32'hB1 || m_rid !== 5'h02 || m_rlast !== 1'b1 || sa_rready !== 2'b10) begin errors++; $display("FAIL order_slv1 got d=%h id=%h l=%b rdy=%b want b1/02/1/10", m_rdata, m_rid, m_rlast, sa_rready); end
        tick();
        vectors++; if (ord_empty !== 1'b1) begin errors++; $display("FAIL order_empty got %b want 1", ord_empty); end
        idle_inputs();
    endtask

    task automatic test_full();
        int cnt;
        for (int i = 0; i < 8; i++) push(1'(i % 2), 3'd0);
        vectors++; if (ord_full !== 1'b1) begin errors++; $display("FAIL full_set got %b want 1", ord_full); end
        push(1'b1, 3'd7);
        vectors++; if (ord_full !== 1'b1) begin errors++; $display("FAIL full_after_drop got %b want 1", ord_full); end
        drive_slv(0, 5'h0, 32'hD0, 2'b00, 1'b1, 1'b1);
        drive_slv(1, 5'h1, 32'hD1, 2'b00, 1'b1, 1'b1);
        m_rready = 1'b1;
        #1;
        vectors++; if (m_rdata !== 32'hD0 || m_rlast !== 1'b1) begin errors++; $display("FAIL full_first got d=%h l=%b want d0/1", m_rdata, m_rlast); end
        tick();
        vectors++; if (ord_full !== 1'b0) begin errors++; $display("FAIL full_clear got %b want 0", ord_full); end
        cnt = 0;
        for (int c = 0; c < 20 && ord_empty !== 1'b1; c++) begin
            vectors++; if (m_rdata !== 32'hD0 + ((cnt + 1) % 2) || m_rlast !== 1'b1) begin errors++; $display("FAIL full_drain%0d got d=%h l=%b want %h/1", cnt, m_rdata, m_rlast, 32'hD0 + ((cnt + 1) % 2)); end
            if (m_rvalid === 1'b1) cnt++;
            tick();
        end
        vectors++; if (cnt !== 7 || ord_empty !== 1'b1) begin errors++; $display("FAIL full_remaining got %0d empty=%b want 7/1", cnt, ord_empty); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        push(1'b0, 3'd0);
        // Pop of the only entry coincides with a new push; the new head steers next cycle.
        drive_slv(0, 5'h0, 32'hF0, 2'b00, 1'b1, 1'b1);
        m_rready = 1'b1;
        ord_push = 1'b1; ord_slv_id = 1'b1; ord_len = 3'd1;
        #1;
        vectors++; if (m_rlast !== 1'b1 || m_rdata !== 32'hF0) begin errors++; $display("FAIL b2b_first got d=%h l=%b want f0/1", m_rdata, m_rlast); end
        tick();
        ord_push = 1'b0;
        vectors++; if (ord_empty !== 1'b0) begin errors++; $display("FAIL b2b_occupancy got empty=%b want 0", ord_empty); end
        for (int b = 0; b < 2; b++) begin
            drive_slv(1, 5'h0, 32'hF8 + b, 2'b00, (b == 1), 1'b1);
            #1;
            vectors++; if (sa_rready !== 2'b10 || m_rvalid !== 1'b1 || m_rdata !== 32'hF8 + b || m_rlast !== (b == 1)) begin errors++; $display("FAIL b2b_beat%0d got rdy=%b v=%b d=%h l=%b want 10/1/%h/%b", b, sa_rready, m_rvalid, m_rdata, m_rlast, 32'hF8 + b, (b == 1)); end
            tick();
        end
        vectors++; if (ord_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", ord_empty); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [4:0] seq;
        int b;
        seq = 5'b10101;
        b = 0;
        push(1'b0, 3'd2);
        for (int c = 0; c < 5; c++) begin
            drive_slv(0, 5'h07, 32'hE0 + b, 2'b10, (b == 2), 1'b1);
            m_rready = seq[4 - c];
            #1;
            vectors++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hE0 + b || m_rlast !== (b == 2) || sa_rready[0] !== seq[4 - c]) begin errors++; $display("FAIL bp_cycle%0d got v=%b d=%h l=%b rdy=%b want 1/%h/%b/%b", c, m_rvalid, m_rdata, m_rlast, sa_rready[0], 32'hE0 + b, (b == 2), seq[4 - c]); end
            tick();
            if (seq[4 - c]) b++;
        end
        vectors++; if (b !== 3 || ord_empty !== 1'b1 || last_err !== 1'b0) begin errors++; $display("FAIL bp_done got beats=%0d empty=%b err=%b want 3/1/0", b, ord_empty, last_err); end
        idle_inputs();
    endtask

    task automatic test_mismatch();
        push(1'b1, 3'd1);
        drive_slv(1, 5'h0, 32'h55, 2'b00, 1'b1, 1'b1);
        m_rready = 1'b1;
        #1;
        vectors++; if (m_rlast !== 1'b0 || last_err !== 1'b0) begin errors++; $display("FAIL mm_beat0 got l=%b err=%b want 0/0", m_rlast, last_err); end
        tick();
        drive_slv(1, 5'h0, 32'h56, 2'b00, 1'b1, 1'b1);
        #1;
        vectors++; if (last_err !== 1'b1 || ord_empty !== 1'b0 || m_rlast !== 1'b1) begin errors++; $display("FAIL mm_pulse got err=%b empty=%b l=%b want 1/0/1", last_err, ord_empty, m_rlast); end
        tick();
        vectors++; if (last_err !== 1'b0 || ord_empty !== 1'b1) begin errors++; $display("FAIL mm_after got err=%b empty=%b want 0/1", last_err, ord_empty); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        push(1'b0, 3'd3);
        drive_slv(0, 5'h0, 32'h77, 2'b00, 1'b0, 1'b1);
        m_rready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (ord_empty !== 1'b1 || ord_full !== 1'b0 || m_rvalid !== 1'b0 || m_rlast !== 1'b0) begin errors++; $display("FAIL rstmid_state got e=%b f=%b v=%b l=%b want 1/0/0/0", ord_empty, ord_full, m_rvalid, m_rlast); end
        vectors++; if (sa_rready !== 2'b00 || last_err !== 1'b0 || m_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_outs got rdy=%b err=%b d=%h want 00/0/0", sa_rready, last_err, m_rdata); end
        push(1'b0, 3'd0);
        drive_slv(0, 5'h0, 32'h78, 2'b00, 1'b1, 1'b1);
        #1;
        vectors++; if (m_rlast !== 1'b1 || m_rdata !== 32'h78) begin errors++; $display("FAIL rstmid_cnt_clear got l=%b d=%h want 1/78", m_rlast, m_rdata); end
        tick();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_ordering();
        test_full();
        test_back_to_back();
        test_backpressure();
        test_mismatch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
